// File: rtl/decode_stage.sv
// decode_stage
//    Two-entry instruction buffer in front of decode. It accepts fetched
//    instructions, holds up to two of them, and presents the oldest (head)
//    entry split into its fields. The head is consumed when downstream is not
//    stalling. A flush drops everything buffered. A retire counter tracks
//    consumed instructions.
//
// Ports
//    clk          clock; all state changes on its rising edge
//    reset        synchronous active-high reset
//    instr        fetched instruction {opcode, rdest, opext/imm_hi, rsrc/imm_lo}
//    instr_valid  instr is valid this cycle
//    instr_ready  buffer can take an instruction this cycle (state only)
//    stall        downstream cannot consume the head entry
//    flush        discard all buffered instructions
//    dec_valid    head entry outputs are valid
//    opcode, rdest, opext, rsrc   head entry fields (0 when empty)
//    upper, lower immediate nibbles for the sign-extender (= opext, rsrc)
//    imm_sel      head entry takes the sign-extended immediate as operand B
//    dec_count    instructions retired since reset, wraps at 16 bits
//
// State | meaning
// EMPTY | no entries buffered, outputs forced to 0
// ONE   | one entry buffered, still accepting
// TWO   | both entries full, instr_valid ignored

module decode_stage #(
   parameter logic [3:0] REG_OP_A = 4'h0,
   parameter logic [3:0] REG_OP_B = 4'h4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic        stall,
   input  logic        flush,
   output logic        dec_valid,
   output logic [3:0]  opcode,
   output logic [3:0]  rdest,
   output logic [3:0]  opext,
   output logic [3:0]  rsrc,
   output logic [3:0]  upper,
   output logic [3:0]  lower,
   output logic        imm_sel,
   output logic [15:0] dec_count
);

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t      state;
   logic        head_ptr;
   logic        tail_ptr;
   logic [15:0] mem [2];
   logic [15:0] head_entry;
   logic        accept;
   logic        consume;

   assign instr_ready = (state == EMPTY) || (state == ONE);
   assign dec_valid   = (state != EMPTY);

   // A flushed cycle never accepts, so a write in that cycle cannot occur.
   assign accept  = instr_valid && instr_ready && !flush;
   assign consume = dec_valid && !stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= EMPTY;
         head_ptr  <= 1'b0;
         tail_ptr  <= 1'b0;
         dec_count <= 16'h0000;
      end else begin
         // A consume coinciding with a flush still counts as retired.
         if (consume)
            dec_count <= dec_count + 16'd1;

         if (flush) begin
            state    <= EMPTY;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
         end else begin
            if (accept)
               tail_ptr <= ~tail_ptr;
            if (consume)
               head_ptr <= ~head_ptr;

            case (state)
               EMPTY: if (accept) state <= ONE;
               ONE: begin
                  if (accept && !consume)
                     state <= TWO;
                  else if (!accept && consume)
                     state <= EMPTY;
               end
               TWO: if (consume) state <= ONE;
               default: state <= EMPTY;
            endcase
         end
      end
   end

   // Storage is not reset; empty slots are masked at the outputs.
   always_ff @(posedge clk) begin
      if (accept && !reset)
         mem[tail_ptr] <= instr;
   end

   always_comb begin
      head_entry = 16'h0000;
      if (dec_valid)
         head_entry = mem[head_ptr];
   end

   assign opcode  = head_entry[15:12];
   assign rdest   = head_entry[11:8];
   assign opext   = head_entry[7:4];
   assign rsrc    = head_entry[3:0];
   assign upper   = head_entry[7:4];
   assign lower   = head_entry[3:0];
   assign imm_sel = dec_valid && (opcode != REG_OP_A) && (opcode != REG_OP_B);

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        stall;
   logic        flush;
   logic        dec_valid;
   logic [3:0]  opcode;
   logic [3:0]  rdest;
   logic [3:0]  opext;
   logic [3:0]  rsrc;
   logic [3:0]  upper;
   logic [3:0]  lower;
   logic        imm_sel;
   logic [15:0] dec_count;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a plain queue of buffered instructions plus a counter.
   logic [15:0] q[$];
   logic [15:0] m_count;

   decode_stage dut (
      .clk         (clk),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .stall       (stall),
      .flush       (flush),
      .dec_valid   (dec_valid),
      .opcode      (opcode),
      .rdest       (rdest),
      .opext       (opext),
      .rsrc        (rsrc),
      .upper       (upper),
      .lower       (lower),
      .imm_sel     (imm_sel),
      .dec_count   (dec_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [15:0] h;
      logic        v;
      logic        isel;
      v = (q.size() > 0);
      h = v ? q[0] : 16'h0000;
      isel = v && (h[15:12] != 4'h0) && (h[15:12] != 4'h4);
      check("dec_valid",   {15'd0, dec_valid},   {15'd0, v});
      check("instr_ready", {15'd0, instr_ready}, {15'd0, q.size() < 2});
      check("opcode",      {12'd0, opcode},      {12'd0, h[15:12]});
      check("rdest",       {12'd0, rdest},       {12'd0, h[11:8]});
      check("opext",       {12'd0, opext},       {12'd0, h[7:4]});
      check("rsrc",        {12'd0, rsrc},        {12'd0, h[3:0]});
      check("upper",       {12'd0, upper},       {12'd0, h[7:4]});
      check("lower",       {12'd0, lower},       {12'd0, h[3:0]});
      check("imm_sel",     {15'd0, imm_sel},     {15'd0, isel});
      check("dec_count",   dec_count,            m_count);
   endtask

   // Drive one cycle, check current outputs against the model, clock it,
   // then advance the model using the same inputs.
   task automatic cycle(input logic v, input logic [15:0] i, input logic s,
                        input logic f, input logic r);
      logic acc;
      logic con;
      reset       = r;
      instr       = i;
      instr_valid = v;
      stall       = s;
      flush       = f;
      #2;
      check_model();
      acc = v && (q.size() < 2);
      con = (q.size() > 0) && !s;
      @(posedge clk);
      if (r) begin
         q.delete();
         m_count = 16'h0000;
      end else begin
         if (con) begin
            m_count = m_count + 16'd1;
            void'(q.pop_front());
         end
         if (f)
            q.delete();
         else if (acc)
            q.push_back(i);
      end
      #1;
   endtask

   initial begin
      logic [15:0] ri;
      logic        rv, rs, rf, rr;
      m_count = 16'h0000;
      reset = 1'b1; instr = 16'h0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      check("rst_dec_valid", {15'd0, dec_valid}, 16'd0);
      check("rst_ready", {15'd0, instr_ready}, 16'd1);
      check("rst_count", dec_count, 16'd0);
      check("rst_opcode", {12'd0, opcode}, 16'd0);

      // Single immediate-format instruction, one cycle latency
      cycle(1'b1, 16'h1A0F, 1'b0, 1'b0, 1'b0);
      check("1a0f_valid", {15'd0, dec_valid}, 16'd1);
      check("1a0f_opcode", {12'd0, opcode}, 16'h1);
      check("1a0f_rdest", {12'd0, rdest}, 16'hA);
      check("1a0f_upper", {12'd0, upper}, 16'h0);
      check("1a0f_lower", {12'd0, lower}, 16'hF);
      check("1a0f_imm_sel", {15'd0, imm_sel}, 16'd1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      check("1a0f_drained", {15'd0, dec_valid}, 16'd0);
      check("1a0f_count", dec_count, 16'd1);

      // Register-format instruction
      cycle(1'b1, 16'h0325, 1'b0, 1'b0, 1'b0);
      check("0325_imm_sel", {15'd0, imm_sel}, 16'd0);
      check("0325_opext", {12'd0, opext}, 16'h2);
      check("0325_rsrc", {12'd0, rsrc}, 16'h5);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Stall with three back-to-back instructions
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 16'h5F80, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 16'h5FFF, 1'b1, 1'b0, 1'b0);
      check("stall_ready_full", {15'd0, instr_ready}, 16'd0);
      cycle(1'b1, 16'h5006, 1'b1, 1'b0, 1'b0);
      check("stall_upper", {12'd0, upper}, 16'h8);
      check("stall_lower", {12'd0, lower}, 16'h0);
      cycle(1'b1, 16'h5006, 1'b1, 1'b0, 1'b0);
      check("stall_hold_upper", {12'd0, upper}, 16'h8);
      check("stall_hold_lower", {12'd0, lower}, 16'h0);
      cycle(1'b1, 16'h5006, 1'b0, 1'b0, 1'b0);
      check("release_second", {12'd0, lower}, 16'hF);
      cycle(1'b1, 16'h5006, 1'b0, 1'b0, 1'b0);
      check("release_third", {12'd0, lower}, 16'h6);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      check("release_count", dec_count, 16'd3);
      check("release_empty", {15'd0, dec_valid}, 16'd0);

      // Steady streaming in ONE
      cycle(1'b1, 16'h2111, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, 16'h2200 + 16'(k), 1'b0, 1'b0, 1'b0);
         check("stream_ready", {15'd0, instr_ready}, 16'd1);
         check("stream_lower", {12'd0, lower}, 16'(k));
      end
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      check("stream_count", dec_count, 16'd10);

      // Flush from TWO with an incoming instruction
      cycle(1'b1, 16'h3123, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 16'h3456, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 16'h7777, 1'b1, 1'b1, 1'b0);
      check("flush_valid", {15'd0, dec_valid}, 16'd0);
      check("flush_ready", {15'd0, instr_ready}, 16'd1);
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      check("flush_absent", {15'd0, dec_valid}, 16'd0);

      // Reset from TWO with a coinciding consume
      cycle(1'b1, 16'h8001, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 16'h8002, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 16'h8003, 1'b0, 1'b0, 1'b1);
      check("midrst_valid", {15'd0, dec_valid}, 16'd0);
      check("midrst_count", dec_count, 16'd0);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         ri = 16'($urandom);
         if ($urandom_range(0, 3) == 0)
            ri[15:12] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h4;
         rv = ($urandom_range(0, 3) != 0);
         rs = ($urandom_range(0, 2) == 0);
         rf = ($urandom_range(0, 15) == 0);
         rr = ($urandom_range(0, 31) == 0);
         cycle(rv, ri, rs, rf, rr);
      end

      // Counter wrap: retire 65536 instructions after reset
      cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 65536; k++)
         cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      check("wrap_ffff", dec_count, 16'hFFFF);
      cycle(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
      check("wrap_zero", dec_count, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter REG_OP_A, default 4'h0, the register-format opcode (ALU reg-reg).
REQ-002 The block SHALL have parameter REG_OP_B, default 4'h4, the register-format opcode (load/store/jump-reg).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port instr, input, 16 bits: fetched instruction, with opcode [15:12], rdest [11:8], opext/imm-high [7:4], rsrc/imm-low [3:0].
REQ-006 The block SHALL have port instr_valid, input, 1 bit: instr is valid this cycle.
REQ-007 The block SHALL have port instr_ready, output, 1 bit: the block accepts instr this cycle.
REQ-008 The block SHALL have port stall, input, 1 bit: downstream cannot consume the head entry.
REQ-009 The block SHALL have port flush, input, 1 bit: discard all buffered instructions (branch taken).
REQ-010 The block SHALL have port dec_valid, output, 1 bit: the head entry outputs are valid.
REQ-011 The block SHALL have ports opcode, rdest, opext and rsrc, each output, 4 bits: decoded fields of the head entry.
REQ-012 The block SHALL have ports upper and lower, each output, 4 bits: immediate nibbles [7:4] and [3:0] of the head entry, which feed the sign-extender inputs of the same names.
REQ-013 The block SHALL have port imm_sel, output, 1 bit: the head entry uses the sign-extended immediate as operand B.
REQ-014 The block SHALL have port dec_count, output, 16 bits: number of instructions retired (consumed) since reset.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of 16-bit instructions with states EMPTY, ONE and TWO, encoded in an occupancy count of 0..2.
REQ-016 instr_ready SHALL be 1 in EMPTY and ONE and 0 in TWO; it SHALL be combinational from state only, with no dependency on instr_valid.
REQ-017 An accept SHALL occur when instr_valid=1 and instr_ready=1; the instruction is written at the tail pointer on that edge.
REQ-018 A consume SHALL occur when dec_valid=1 and stall=0; the head pointer advances on that edge and dec_count increments by 1.
REQ-019 dec_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-020 Transitions SHALL be: EMPTY->ONE on accept; ONE->TWO on accept without consume; ONE->EMPTY on consume without accept; ONE->ONE on simultaneous accept and consume; TWO->ONE on consume.
REQ-021 The block SHALL ignore instr_valid in TWO (no accept).
REQ-022 The head and tail pointers SHALL be 1 bit each and wrap modulo 2.
REQ-023 dec_valid SHALL be 1 exactly when state != EMPTY.
REQ-024 Latency SHALL be one cycle: an instruction accepted at edge N appears on the outputs after edge N when the FIFO was EMPTY, with no combinational bypass from instr to the outputs.
REQ-025 The field outputs SHALL be combinational from the head entry; when dec_valid=0, opcode, rdest, opext, rsrc, upper, lower and imm_sel SHALL all be 0.
REQ-026 imm_sel SHALL be 0 when opcode is REG_OP_A or REG_OP_B, and 1 otherwise (dec_valid=1).
REQ-027 upper SHALL equal opext and lower SHALL equal rsrc at all times.
REQ-028 flush=1 SHALL force the state to EMPTY and reset both pointers to 0 on the next edge.
REQ-029 flush SHALL take priority over a same-cycle accept, which is discarded.
REQ-030 A same-cycle consume SHALL still increment dec_count during a flush.
REQ-031 The contents of a stalled head entry SHALL remain stable for every cycle that stall=1.

Reset
REQ-032 On reset=1 at a rising edge, the block SHALL set state EMPTY, both pointers 0 and dec_count 0.
REQ-033 Reset SHALL have priority over flush, accept and consume.
REQ-034 Immediately after reset, outputs SHALL be dec_valid=0, instr_ready=1, all field outputs 0 and dec_count=0.
REQ-035 Storage contents need not be cleared on reset.
REQ-036 Reset asserted mid-operation (state ONE or TWO) SHALL discard all entries and SHALL NOT increment dec_count, even if a consume coincides with it.

Verification
REQ-037 A bench SHALL cover: reset, then instr=16'h1A0F with instr_valid=1 for one cycle and stall=0 -> next cycle dec_valid=1, opcode=1, rdest=A, upper=0, lower=F, imm_sel=1; the cycle after that dec_valid=0 and dec_count=1.
REQ-038 A bench SHALL cover: instr=16'h0325 (REG_OP_A) -> imm_sel=0, opext=2, rsrc=5.
REQ-039 A bench SHALL cover: stall=1 with 3 back-to-back valid instructions 16'h5F80, 16'h5FFF, 16'h5006 -> instr_ready=0 after two accepts and the third is held off; outputs remain upper=8, lower=0 while stalled; releasing stall retires them in order, giving dec_count=3.
REQ-040 A bench SHALL cover: state ONE with instr_valid=1 and stall=0 held continuously -> state stays ONE, one instruction retired per cycle, instr_ready stays 1.
REQ-041 A bench SHALL cover: state TWO, flush=1 with instr_valid=1 -> next cycle dec_valid=0, instr_ready=1, and the incoming instruction is absent.
REQ-042 A bench SHALL cover: state TWO, reset=1 -> next cycle dec_valid=0 and dec_count=0; then dec_count preloaded near wrap by retiring 65536 instructions -> dec_count returns to 0.
